// File: rtl/ap_file_if.sv
// rtl/ap_file_if.sv - Sequencer-to-pointer-file operation and address bus
`timescale 1ns/1ps
interface ap_file_if #(
  parameter int AW = 16
);
  logic [2:0]    APSel;
  logic [2:0]    APOp;
  logic [AW-1:0] APData;
  logic [AW-1:0] APAddr;
  logic          APAddrValid;
  logic          APWrap;

  modport master (
    output APSel, APOp, APData,
    input  APAddr, APAddrValid, APWrap
  );

  modport slave (
    input  APSel, APOp, APData,
    output APAddr, APAddrValid, APWrap
  );
endinterface

// File: rtl/ap_file.sv
// rtl/ap_file.sv - Eight-entry address-pointer file with optional circular limits
`timescale 1ns/1ps
module ap_file #(
  parameter int AW = 16
) (
  input  logic       clk,
  input  logic       rst,
  ap_file_if.slave   ap
);
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LOAD    = 3'd1,
    OP_READ    = 3'd2,
    OP_POSTINC = 3'd3,
    OP_PREDEC  = 3'd4,
    OP_ADDOFS  = 3'd5,
    OP_SETLIM  = 3'd6,
    OP_CLRALL  = 3'd7
  } ap_op_e;

  logic [AW-1:0] ptr_q [8];
  logic [AW-1:0] ptr_d [8];
  logic [AW-1:0] lim_q [8];
  logic [AW-1:0] lim_d [8];
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;

  logic [AW-1:0] cur, cur_lim, nxt, prv;
  logic          circ, nxt_wrap, prv_wrap;

  always_comb begin
    cur     = ptr_q[ap.APSel];
    cur_lim = lim_q[ap.APSel];
    circ    = (cur_lim != '0);

    // A pointer already beyond a freshly lowered limit also snaps back to 0.
    if (circ && (cur >= cur_lim)) begin
      nxt      = '0;
      nxt_wrap = 1'b1;
    end else begin
      nxt      = cur + AW'(1);
      nxt_wrap = &cur;
    end

    if (cur == '0) begin
      prv      = circ ? cur_lim : '1;
      prv_wrap = 1'b1;
    end else begin
      prv      = cur - AW'(1);
      prv_wrap = 1'b0;
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    lim_d   = lim_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    case (ap_op_e'(ap.APOp))
      OP_LOAD:    ptr_d[ap.APSel] = ap.APData;
      OP_READ: begin
        addr_d  = cur;
        valid_d = 1'b1;
      end
      OP_POSTINC: begin
        addr_d          = cur;
        ptr_d[ap.APSel] = nxt;
        valid_d         = 1'b1;
        wrap_d          = nxt_wrap;
      end
      OP_PREDEC: begin
        addr_d          = prv;
        ptr_d[ap.APSel] = prv;
        valid_d         = 1'b1;
        wrap_d          = prv_wrap;
      end
      OP_ADDOFS: begin
        addr_d  = cur + ap.APData;
        valid_d = 1'b1;
      end
      OP_SETLIM:  lim_d[ap.APSel] = ap.APData;
      OP_CLRALL: begin
        for (int i = 0; i < 8; i++) begin
          ptr_d[i] = '0;
          lim_d[i] = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        ptr_q[i] <= '0;
        lim_q[i] <= '0;
      end
      addr_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      lim_q   <= lim_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign ap.APAddr      = addr_q;
  assign ap.APAddrValid = valid_q;
  assign ap.APWrap      = wrap_q;
endmodule

// File: tb/tb_ap_file.sv
// tb/tb_ap_file.sv - Randomized and directed bench for ap_file against a reference model
`timescale 1ns/1ps
module tb_ap_file;
  localparam int AW  = 16;
  localparam int MOD = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_ptr [8];
  int m_lim [8];
  int m_addr;
  int e_valid;
  int e_wrap;

  ap_file_if #(.AW(AW)) bus ();

  ap_file #(.AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .ap  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_ptr[i] = 0;
      m_lim[i] = 0;
    end
    m_addr  = 0;
    e_valid = 0;
    e_wrap  = 0;
  endtask

  task automatic model_step(input int op, input int s, input int d);
    int x, l;
    x = m_ptr[s];
    l = m_lim[s];
    e_valid = 0;
    e_wrap  = 0;
    case (op)
      1: m_ptr[s] = d;
      2: begin m_addr = x; e_valid = 1; end
      3: begin
        m_addr  = x;
        e_valid = 1;
        if (l != 0 && x >= l) begin
          m_ptr[s] = 0;
          e_wrap   = 1;
        end else begin
          e_wrap   = (x + 1 == MOD);
          m_ptr[s] = (x + 1) % MOD;
        end
      end
      4: begin
        if (x == 0) begin
          m_ptr[s] = (l != 0) ? l : MOD - 1;
          e_wrap   = 1;
        end else begin
          m_ptr[s] = x - 1;
        end
        m_addr  = m_ptr[s];
        e_valid = 1;
      end
      5: begin m_addr = (x + d) % MOD; e_valid = 1; end
      6: m_lim[s] = d;
      7: for (int i = 0; i < 8; i++) begin m_ptr[i] = 0; m_lim[i] = 0; end
      default: ;
    endcase
  endtask

  // Called just after a rising edge; issues one op and checks the registered result.
  task automatic do_op(input int op, input int s, input int d);
    bus.APOp   = op[2:0];
    bus.APSel  = s[2:0];
    bus.APData = d[AW-1:0];
    model_step(op, s, d);
    @(posedge clk);
    #1;
    check("addr",  int'(bus.APAddr),      m_addr);
    check("valid", int'(bus.APAddrValid), e_valid);
    check("wrap",  int'(bus.APWrap),      e_wrap);
  endtask

  int op, s, d;

  initial begin
    bus.APOp   = '0;
    bus.APSel  = '0;
    bus.APData = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr",  int'(bus.APAddr), 0);
    check("rst_valid", int'(bus.APAddrValid), 0);
    check("rst_wrap",  int'(bus.APWrap), 0);
    rst = 1'b0;

    for (int p = 0; p < 8; p++) begin
      do_op(2, p, 16'hABCD);
      check("rst_read", int'(bus.APAddr), 0);
    end

    do_op(1, 3, 16'h1000);
    for (int k = 0; k < 3; k++) begin
      do_op(3, 3, 0);
      check("inc_seq", int'(bus.APAddr), 16'h1000 + k);
    end
    do_op(2, 3, 0);
    check("inc_read", int'(bus.APAddr), 16'h1003);
    do_op(2, 0, 0);
    check("other_ptr", int'(bus.APAddr), 0);

    do_op(6, 5, 16'h0003);
    do_op(1, 5, 16'h0002);
    do_op(3, 5, 0);
    check("circ_a0", int'(bus.APAddr), 2);
    check("circ_w0", int'(bus.APWrap), 0);
    do_op(3, 5, 0);
    check("circ_a1", int'(bus.APAddr), 3);
    check("circ_w1", int'(bus.APWrap), 1);
    do_op(3, 5, 0);
    check("circ_a2", int'(bus.APAddr), 0);
    do_op(4, 5, 0);
    do_op(4, 5, 0);
    check("circ_dec_a", int'(bus.APAddr), 3);
    check("circ_dec_w", int'(bus.APWrap), 1);

    do_op(1, 1, 16'hFFFF);
    do_op(3, 1, 0);
    check("lin_a", int'(bus.APAddr), 16'hFFFF);
    check("lin_w", int'(bus.APWrap), 1);
    do_op(2, 1, 0);
    check("lin_read", int'(bus.APAddr), 0);

    do_op(1, 2, 16'hFFF0);
    do_op(5, 2, 16'h0020);
    check("ofs_a", int'(bus.APAddr), 16'h0010);
    check("ofs_w", int'(bus.APWrap), 0);
    do_op(2, 2, 0);
    check("ofs_read", int'(bus.APAddr), 16'hFFF0);

    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 7);
      if (op == 7 && $urandom_range(0, 3) != 0) op = 3;
      s = $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0: d = $urandom & 16'hFFFF;
        1: d = $urandom_range(0, 8);
        2: d = 16'hFFFF - $urandom_range(0, 3);
        default: d = $urandom_range(0, 20);
      endcase
      do_op(op, s, d);
    end

    do_op(1, 4, 16'h0020);
    do_op(3, 4, 0);
    do_op(3, 4, 0);
    bus.APOp  = 3'd3;
    bus.APSel = 3'd4;
    #2;
    rst = 1'b1;
    #0.5;
    check("arst_addr",  int'(bus.APAddr), 0);
    check("arst_valid", int'(bus.APAddrValid), 0);
    check("arst_wrap",  int'(bus.APWrap), 0);
    #0.5;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    do_op(2, 4, 0);
    check("arst_read", int'(bus.APAddr), 0);
    check("arst_rv",   int'(bus.APAddrValid), 1);

    for (int n = 0; n < 200; n++) begin
      do_op($urandom_range(0, 6), $urandom_range(0, 7), $urandom_range(0, 12));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
